// File: rtl/leb128_decoder_if.sv
// Request/response and ROM-port bundle for leb128_decoder.
// master = core + ROM side, slave = decoder.
interface leb128_decoder_if #(
  parameter int unsigned MEM_DEPTH = 4,
  parameter int unsigned MEM_EXTRA = 4
);
  localparam int unsigned AW = MEM_DEPTH + 1;
  localparam int unsigned DW = (2 ** MEM_EXTRA) * 8;

  logic          start;
  logic [AW-1:0] pc;
  logic          is_signed;
  logic          is_64;
  logic          busy;
  logic          done;
  logic [63:0]   value;
  logic [3:0]    length;
  logic [AW-1:0] next_pc;
  logic [1:0]    error;
  logic [AW-1:0] mem_addr;
  logic [MEM_EXTRA-1:0] mem_extra;
  logic [DW-1:0] mem_data;
  logic          mem_error;

  modport master (
    output start, pc, is_signed, is_64, mem_data, mem_error,
    input  busy, done, value, length, next_pc, error, mem_addr, mem_extra
  );

  modport slave (
    input  start, pc, is_signed, is_64, mem_data, mem_error,
    output busy, done, value, length, next_pc, error, mem_addr, mem_extra
  );
endinterface

// File: rtl/leb128_decoder.sv
// LEB128 immediate fetcher/decoder over a one-cycle-latency ROM port.
// Optional LEB128_STRICT_EN: range-check the final permitted byte (error 2 on violation).
module leb128_decoder #(
  parameter int unsigned MEM_DEPTH = 4,
  parameter int unsigned MEM_EXTRA = 4
) (
  input  logic             clk,
  input  logic             reset,
  leb128_decoder_if.slave  bus
);
  localparam int unsigned AW = MEM_DEPTH + 1;
  localparam int unsigned DW = (2 ** MEM_EXTRA) * 8;

  typedef enum logic {IDLE, READ} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          sgn_q, sgn_d;
  logic          w64_q, w64_d;
  logic          vld_q, vld_d;
  logic [63:0]   acc_q, acc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [63:0]   value_q, value_d;
  logic [3:0]    length_q, length_d;
  logic [AW-1:0] next_pc_q, next_pc_d;
  logic [1:0]    error_q, error_d;

  logic [7:0]    byte_c;
  logic [3:0]    cnt_inc_c;
  logic          last_c;
  logic [63:0]   merged_c;
  logic [63:0]   ext_c;
  logic [63:0]   final_c;
  logic          strict_bad_c;
  logic          unused_c;

  assign byte_c    = bus.mem_data[7:0];
  assign unused_c  = ^bus.mem_data[DW-1:8];
  assign cnt_inc_c = length_q + 4'd1;
  assign last_c    = (length_q == (w64_q ? 4'd9 : 4'd4));

  // Merge the 7 payload bits at position 7*i, then sign/zero extend.
  always_comb begin
    merged_c = acc_q | (64'(byte_c[6:0]) << (7'(length_q) * 7'd7));
    ext_c    = merged_c;
    if (sgn_q && byte_c[6]) begin
      ext_c = merged_c | (~64'd0 << (7'(cnt_inc_c) * 7'd7));
    end
    if (w64_q) begin
      final_c = ext_c;
    end else begin
      final_c = {(sgn_q ? {32{ext_c[31]}} : 32'd0), ext_c[31:0]};
    end
  end

`ifdef LEB128_STRICT_EN
  // Excess bits of the final byte must be a pure extension of the value.
  always_comb begin
    strict_bad_c = 1'b0;
    if (!sgn_q) begin
      strict_bad_c = w64_q ? (|byte_c[6:1]) : (|byte_c[6:4]);
    end else if (w64_q) begin
      strict_bad_c = !((byte_c[6:0] == 7'h00) || (byte_c[6:0] == 7'h7F));
    end else begin
      strict_bad_c = !((byte_c[6:3] == 4'h0) || (byte_c[6:3] == 4'hF));
    end
  end
`else
  assign strict_bad_c = 1'b0;
`endif

  always_comb begin
    logic          fin;
    logic [1:0]    fin_err;
    logic [3:0]    fin_len;
    logic [63:0]   fin_val;

    state_d   = state_q;
    pc_d      = pc_q;
    sgn_d     = sgn_q;
    w64_d     = w64_q;
    vld_d     = vld_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    value_d   = value_q;
    length_d  = length_q;
    next_pc_d = next_pc_q;
    error_d   = error_q;
    fin       = 1'b0;
    fin_err   = 2'd0;
    fin_len   = cnt_inc_c;
    fin_val   = 64'd0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = READ;
          pc_d     = bus.pc;
          sgn_d    = bus.is_signed;
          w64_d    = bus.is_64;
          vld_d    = 1'b0;
          acc_d    = 64'd0;
          length_d = 4'd0;
          error_d  = 2'd0;
          addr_d   = bus.pc;
          busy_d   = 1'b1;
        end
      end
      READ: begin
        addr_d = addr_q + AW'(1);
        vld_d  = 1'b1;
        // First READ cycle only issues; data for the first address lands next.
        if (vld_q) begin
          if (bus.mem_error) begin
            fin     = 1'b1;
            fin_err = 2'd1;
            fin_len = length_q;
          end else if (byte_c[7]) begin
            if (last_c) begin
              fin     = 1'b1;
              fin_err = 2'd2;
            end else begin
              acc_d    = merged_c;
              length_d = cnt_inc_c;
            end
          end else if (last_c && strict_bad_c) begin
            fin     = 1'b1;
            fin_err = 2'd2;
          end else begin
            fin     = 1'b1;
            fin_val = final_c;
          end
        end
        if (fin) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          value_d   = fin_val;
          length_d  = fin_len;
          error_d   = fin_err;
          next_pc_d = pc_q + AW'(fin_len);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      sgn_q     <= 1'b0;
      w64_q     <= 1'b0;
      vld_q     <= 1'b0;
      acc_q     <= 64'd0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      value_q   <= 64'd0;
      length_q  <= 4'd0;
      next_pc_q <= '0;
      error_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      sgn_q     <= sgn_d;
      w64_q     <= w64_d;
      vld_q     <= vld_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      value_q   <= value_d;
      length_q  <= length_d;
      next_pc_q <= next_pc_d;
      error_q   <= error_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.value     = value_q;
  assign bus.length    = length_q;
  assign bus.next_pc   = next_pc_q;
  assign bus.error     = error_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_extra = '0;

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder: vector table plus multi-cycle corner sequences.
module tb_leb128_decoder;
  localparam int unsigned MEM_DEPTH = 4;
  localparam int unsigned MEM_EXTRA = 4;
  localparam int unsigned AW = MEM_DEPTH + 1;
  localparam int unsigned DW = (2 ** MEM_EXTRA) * 8;
  localparam int unsigned ROM_UPPER_BOUND = 29;
  localparam int NVEC = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  leb128_decoder_if #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) bus ();

  leb128_decoder #(.MEM_DEPTH(MEM_DEPTH), .MEM_EXTRA(MEM_EXTRA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ROM model: registered data and bounds flag, one cycle behind the address.
  logic [7:0] rom [32];
  always @(posedge clk) begin
    bus.mem_data  <= {{(DW-8){1'b0}}, rom[bus.mem_addr]};
    bus.mem_error <= (32'(bus.mem_addr) > ROM_UPPER_BOUND);
  end

  typedef struct {
    logic [AW-1:0] pc;
    logic          s;
    logic          w;
    logic [63:0]   val;
    logic [3:0]    len;
    logic [AW-1:0] npc;
    logic [1:0]    err;
    int            lat;
  } vec_t;

  vec_t vecs [NVEC];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start (caller is #1 after an edge); returns cycles until done, -1 on timeout.
  task automatic go(input logic [AW-1:0] p, input logic s, input logic w, output int lat);
    bus.pc = p; bus.is_signed = s; bus.is_64 = w; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
  endtask

  initial begin
    int lat;
    logic seen;
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    rom[0]  = 8'hE5; rom[1]  = 8'h8E; rom[2]  = 8'h26;
    rom[3]  = 8'hC0; rom[4]  = 8'hBB; rom[5]  = 8'h78;
    rom[6]  = 8'h7F;
    rom[7]  = 8'hFF; rom[8]  = 8'hFF; rom[9]  = 8'hFF; rom[10] = 8'hFF; rom[11] = 8'h7F;
    for (int i = 12; i < 17; i++) rom[i] = 8'h80;
    rom[17] = 8'h00;
    rom[18] = 8'h80; rom[19] = 8'h80; rom[20] = 8'h80; rom[21] = 8'h01;
    rom[22] = 8'h00; rom[23] = 8'h40;
    rom[24] = 8'h80; rom[25] = 8'h80; rom[26] = 8'h80; rom[27] = 8'h80; rom[28] = 8'h01;
    rom[29] = 8'h81; rom[30] = 8'h00; rom[31] = 8'h00;

    vecs[0]  = '{5'd0,  1'b0, 1'b0, 64'd624485,                4'd3, 5'd3,  2'd0, 4};
    vecs[1]  = '{5'd3,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFE_1DC0,   4'd3, 5'd6,  2'd0, 4};
    vecs[2]  = '{5'd6,  1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF,   4'd1, 5'd7,  2'd0, 2};
`ifdef LEB128_STRICT_EN
    vecs[3]  = '{5'd7,  1'b0, 1'b0, 64'd0,                     4'd5, 5'd12, 2'd2, 6};
`else
    vecs[3]  = '{5'd7,  1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF,   4'd5, 5'd12, 2'd0, 6};
`endif
    vecs[4]  = '{5'd7,  1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,   4'd5, 5'd12, 2'd0, 6};
    vecs[5]  = '{5'd12, 1'b0, 1'b0, 64'd0,                     4'd5, 5'd17, 2'd2, 6};
    vecs[6]  = '{5'd24, 1'b0, 1'b0, 64'h0000_0000_1000_0000,   4'd5, 5'd29, 2'd0, 6};
    vecs[7]  = '{5'd24, 1'b0, 1'b1, 64'h0000_0000_1000_0000,   4'd5, 5'd29, 2'd0, 6};
    vecs[8]  = '{5'd29, 1'b0, 1'b1, 64'd0,                     4'd1, 5'd30, 2'd1, 3};
    vecs[9]  = '{5'd31, 1'b0, 1'b0, 64'd0,                     4'd0, 5'd31, 2'd1, 2};
    vecs[10] = '{5'd22, 1'b0, 1'b0, 64'd0,                     4'd1, 5'd23, 2'd0, 2};
    vecs[11] = '{5'd23, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0,   4'd1, 5'd24, 2'd0, 2};

    bus.start = 1'b0; bus.pc = '0; bus.is_signed = 1'b0; bus.is_64 = 1'b0;
    bus.mem_data = '0; bus.mem_error = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_value", bus.value, 64'd0);
    chk("rst_length", 64'(bus.length), 64'd0);
    chk("rst_next_pc", 64'(bus.next_pc), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_mem_extra", 64'(bus.mem_extra), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      go(vecs[i].pc, vecs[i].s, vecs[i].w, lat);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_value", i), bus.value, vecs[i].val);
      chk($sformatf("v%0d_length", i), 64'(bus.length), 64'(vecs[i].len));
      chk($sformatf("v%0d_next_pc", i), 64'(bus.next_pc), 64'(vecs[i].npc));
      chk($sformatf("v%0d_error", i), 64'(bus.error), 64'(vecs[i].err));
      chk($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
    end

    // start held high while busy must not launch a second decode
    bus.pc = 5'd6; bus.is_signed = 1'b1; bus.is_64 = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 bus.pc = 5'd0;
    @(posedge clk); #1;
    chk("ign_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    chk("ign_done", 64'(bus.done), 64'd1);
    chk("ign_value", bus.value, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.start = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("ign_no_second", 64'(seen), 64'd0);

    // start coinciding with the done pulse is accepted
    go(5'd22, 1'b0, 1'b0, lat);
    chk("b2b_first_lat", 64'(lat), 64'd2);
    bus.pc = 5'd23; bus.is_signed = 1'b1; bus.is_64 = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_done", 64'(bus.done), 64'd1);
    chk("b2b_value", bus.value, 64'hFFFF_FFFF_FFFF_FFC0);
    chk("b2b_next_pc", 64'(bus.next_pc), 64'd24);

    // reset during byte index 1 of a 4-byte decode
    bus.pc = 5'd18; bus.is_signed = 1'b0; bus.is_64 = 1'b1; bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_value", bus.value, 64'd0);
    chk("mid_rst_length", 64'(bus.length), 64'd0);
    chk("mid_rst_next_pc", 64'(bus.next_pc), 64'd0);
    chk("mid_rst_error", 64'(bus.error), 64'd0);
    chk("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    go(5'd18, 1'b0, 1'b1, lat);
    chk("post_rst_lat", 64'(lat), 64'd5);
    chk("post_rst_value", bus.value, 64'h0000_0000_0020_0000);
    chk("post_rst_length", 64'(bus.length), 64'd4);
    chk("post_rst_next_pc", 64'(bus.next_pc), 64'd22);
    chk("post_rst_error", 64'(bus.error), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
